// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-granular round-robin arbiter that shares one
// router injection port among NUM_REQ flit sources. A source that wins keeps
// the port until its tail flit, so packets never interleave. A local credit
// counter mirrors the free slots of the router input buffer.
module noc_inject_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*DEST_WIDTH-1:0] req_dest,
    input  logic [NUM_REQ-1:0]            req_is_tail,
    output logic [FLIT_WIDTH-1:0]         data_out,
    output logic [DEST_WIDTH-1:0]         dest_out,
    output logic                          is_tail_out,
    output logic                          send_out,
    input  logic                          credit_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          credit_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);
    localparam logic [CW-1:0]  CREDIT_ONE = CW'(1);
    localparam logic [IDW-1:0] ID_ONE     = IDW'(1);
    localparam logic [IDW-1:0] ID_LAST    = IDW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Next index after v, wrapping at NUM_REQ (which need not be a power of 2).
    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] v);
        logic [IDW-1:0] r;
        if (v == ID_LAST) begin
            r = {IDW{1'b0}};
        end else begin
            r = v + ID_ONE;
        end
        return r;
    endfunction

    // Round-robin search: first valid index scanning ptr, ptr+1, ... mod NUM_REQ.
    // Result is {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
        logic           found;
        logic [IDW-1:0] idx;
        int             pos;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end else begin
                pos = pos;
            end
            if (!found && valid[IDW'(pos)]) begin
                found = 1'b1;
                idx   = IDW'(pos);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [CW-1:0]   credits_q;
    logic            credit_err_q;
    logic [FLIT_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic            tail_q;
    logic            send_q;

    logic            can_send_s;
    logic [IDW:0]    pick_s;
    logic [IDW-1:0]  sel_s;
    logic            accept_s;
    logic [FLIT_WIDTH-1:0] sel_data_s;
    logic [DEST_WIDTH-1:0] sel_dest_s;
    logic            sel_tail_s;

    assign can_send_s = (credits_q != {CW{1'b0}});
    assign pick_s     = rr_pick(req_valid, rr_ptr_q);
    assign accept_s   = |(req_valid & req_ready);
    assign sel_data_s = req_data[int'(sel_s) * FLIT_WIDTH +: FLIT_WIDTH];
    assign sel_dest_s = req_dest[int'(sel_s) * DEST_WIDTH +: DEST_WIDTH];
    assign sel_tail_s = req_is_tail[sel_s];

    // Arbitration FSM: choose the source to ready this cycle and the next state.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        sel_s     = grant_q;
        req_ready = {NUM_REQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (can_send_s && pick_s[IDW]) begin
                    sel_s            = pick_s[IDW-1:0];
                    req_ready[sel_s] = 1'b1;
                    grant_d          = sel_s;
                    if (req_is_tail[sel_s]) begin
                        rr_ptr_d = inc_mod(sel_s);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Only the owner may send; a stalled owner keeps the port.
                req_ready[grant_q] = can_send_s;
                if (can_send_s && req_valid[grant_q] && req_is_tail[grant_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = inc_mod(grant_q);
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, round-robin pointer and grant owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= {IDW{1'b0}};
            grant_q  <= {IDW{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // Credit counter mirroring free router buffer slots; flags over-return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q    <= CREDIT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            case ({accept_s, credit_in})
                2'b10: begin
                    credits_q <= credits_q - CREDIT_ONE;
                end
                2'b01: begin
                    if (credits_q == CREDIT_MAX) begin
                        credit_err_q <= 1'b1;
                    end else begin
                        credits_q <= credits_q + CREDIT_ONE;
                    end
                end
                default: begin
                    credits_q <= credits_q;
                end
            endcase
        end
    end

    // Output register: accepted flit goes to the router one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {FLIT_WIDTH{1'b0}};
            dest_q <= {DEST_WIDTH{1'b0}};
            tail_q <= 1'b0;
            send_q <= 1'b0;
        end else begin
            send_q <= accept_s;
            if (accept_s) begin
                data_q <= sel_data_s;
                dest_q <= sel_dest_s;
                tail_q <= sel_tail_s;
            end else begin
                data_q <= data_q;
                dest_q <= dest_q;
                tail_q <= tail_q;
            end
        end
    end

    assign data_out    = data_q;
    assign dest_out    = dest_q;
    assign is_tail_out = tail_q;
    assign send_out    = send_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ST_LOCKED);
    assign credit_err  = credit_err_q;

endmodule
